// File: rtl/miss_repair_engine.sv
// rtl/miss_repair_engine.sv - refills one missed cache line from memory, merges store data, returns load word
module miss_repair_engine #(
    parameter int LINE_WORDS  = 4,
    parameter int ROB_ENTRIES = 32,
    localparam int RBW = $clog2(ROB_ENTRIES),
    localparam int CW  = $clog2(LINE_WORDS),
    localparam int OFF = 2 + CW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            repair_req,
    input  logic [31:0]     repair_req_addr,
    input  logic [31:0]     repair_req_data,
    input  logic [RBW-1:0]  repair_req_rob_idx,
    input  logic            repair_is_store,
    output logic            repair_ack,
    output logic            repair_complete,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [31:0]     mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            fill_en,
    output logic [31:0]     fill_addr,
    output logic [31:0]     fill_data,
    output logic            fill_last,
    output logic            ld_wb_valid,
    output logic [RBW-1:0]  ld_wb_rob_idx,
    output logic [31:0]     ld_wb_data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:2]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [RBW-1:0] rob_q, rob_d;
    logic           store_q, store_d;
    logic [31:0]    ld_q, ld_d;

    // Byte offset within a word is meaningless for full-word ops.
    logic unused_byte_offset;
    assign unused_byte_offset = ^repair_req_addr[1:0];

    logic [CW-1:0] word_idx;
    logic [31:0]   line_base;
    logic          beat;
    logic          hit_word;

    assign word_idx  = addr_q[OFF-1:2];
    assign line_base = {addr_q[31:OFF], {OFF{1'b0}}};
    assign beat      = (state_q == RESP) && mem_rsp_valid;
    assign hit_word  = (cnt_q == word_idx);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rob_d   = rob_q;
        store_d = store_q;
        ld_d    = ld_q;
        case (state_q)
            IDLE: begin
                if (repair_req) begin
                    addr_d  = repair_req_addr[31:2];
                    data_d  = repair_req_data;
                    rob_d   = repair_req_rob_idx;
                    store_d = repair_is_store;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = RESP;
            end
            RESP: begin
                if (mem_rsp_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!store_q && hit_word) ld_d = mem_rsp_data;
                    if (cnt_q == CW'(LINE_WORDS - 1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rob_q   <= '0;
            store_q <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rob_q   <= rob_d;
            store_q <= store_d;
            ld_q    <= ld_d;
        end
    end

    // Ack is gated by rst so no output is high while reset is held.
    assign repair_ack      = (state_q == IDLE) && repair_req && !rst;
    assign repair_complete = (state_q == DONE);
    assign mem_req_valid   = (state_q == REQ);
    assign mem_req_addr    = mem_req_valid ? line_base : 32'h0;

    assign fill_en   = beat;
    assign fill_addr = beat ? {addr_q[31:OFF], cnt_q, 2'b00} : 32'h0;
    assign fill_data = !beat ? 32'h0 : ((store_q && hit_word) ? data_q : mem_rsp_data);
    assign fill_last = beat && (cnt_q == CW'(LINE_WORDS - 1));

    assign ld_wb_valid   = (state_q == DONE) && !store_q;
    assign ld_wb_rob_idx = ld_wb_valid ? rob_q : '0;
    assign ld_wb_data    = ld_wb_valid ? ld_q : 32'h0;
endmodule

// File: tb/tb_miss_repair_engine.sv
// tb/tb_miss_repair_engine.sv - directed self-checking bench for miss_repair_engine
module tb_miss_repair_engine;
    logic        clk;
    logic        rst;
    logic        repair_req;
    logic [31:0] repair_req_addr;
    logic [31:0] repair_req_data;
    logic [4:0]  repair_req_rob_idx;
    logic        repair_is_store;
    logic        repair_ack;
    logic        repair_complete;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        fill_en;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        fill_last;
    logic        ld_wb_valid;
    logic [4:0]  ld_wb_rob_idx;
    logic [31:0] ld_wb_data;

    miss_repair_engine dut (
        .clk(clk), .rst(rst),
        .repair_req(repair_req), .repair_req_addr(repair_req_addr),
        .repair_req_data(repair_req_data), .repair_req_rob_idx(repair_req_rob_idx),
        .repair_is_store(repair_is_store), .repair_ack(repair_ack),
        .repair_complete(repair_complete), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
        .fill_last(fill_last), .ld_wb_valid(ld_wb_valid),
        .ld_wb_rob_idx(ld_wb_rob_idx), .ld_wb_data(ld_wb_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] f_addr[$];
    logic [31:0] f_data[$];
    bit          f_last[$];
    int          ack_q[$];
    int          cmp_q[$];
    int          wb_cnt;
    logic [31:0] wb_data;
    logic [4:0]  wb_rob;
    int          overlap;
    bit          busy;

    logic any_out;
    assign any_out = repair_ack | repair_complete | mem_req_valid | (|mem_req_addr) | fill_en
                   | (|fill_addr) | (|fill_data) | fill_last | ld_wb_valid | (|ld_wb_rob_idx)
                   | (|ld_wb_data);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fill_en) begin
            f_addr.push_back(fill_addr);
            f_data.push_back(fill_data);
            f_last.push_back(fill_last);
        end
        if (repair_ack) begin
            ack_q.push_back(cyc);
            if (busy) overlap++;
            busy = 1'b1;
        end
        if (repair_complete) begin
            cmp_q.push_back(cyc);
            busy = 1'b0;
        end
        if (ld_wb_valid) begin
            wb_cnt++;
            wb_data = ld_wb_data;
            wb_rob  = ld_wb_rob_idx;
        end
    end

    task automatic clear_log();
        f_addr.delete(); f_data.delete(); f_last.delete();
        ack_q.delete(); cmp_q.delete();
        wb_cnt = 0; wb_data = 0; wb_rob = 0; overlap = 0; busy = 1'b0;
    endtask

    // Issue one repair and feed four back-to-back beats (bb, bb+1, ...).
    task automatic run_repair(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rob,
                              input bit st, input logic [31:0] bb);
        int n;
        @(posedge clk); #1;
        repair_req = 1'b1; repair_req_addr = a; repair_req_data = d;
        repair_req_rob_idx = rob; repair_is_store = st; mem_req_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!repair_ack && n < 10) begin @(negedge clk); n++; end
        if (!repair_ack) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no ack in %0d cycles, required ack", n);
        end
        @(posedge clk); #1;
        repair_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mem_rsp_valid = 1'b1; mem_rsp_data = bb + i;
        end
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; repair_req = 1'b1; repair_req_addr = 32'h1234; repair_req_data = 32'h55;
        repair_req_rob_idx = 5'd3; repair_is_store = 1'b0; mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
        #12;
        checks++;
        if (any_out !== 1'b0) begin errors++; $display("FAIL reset_outputs: got %b required 0", any_out); end
        repair_req = 1'b0; mem_rsp_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (any_out !== 1'b0) begin errors++; $display("FAIL idle_outputs: got %b required 0", any_out); end
    endtask

    task automatic test_load_miss();
        clear_log();
        run_repair(32'h0000_1238, 32'h0, 5'd5, 1'b0, 32'hA000_0000);
        checks++;
        if (f_addr.size() !== 4) begin errors++; $display("FAIL load_fill_count: got %0d required 4", f_addr.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (f_addr[i] !== 32'h1230 + 4*i || f_data[i] !== 32'hA000_0000 + i || f_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL load_fill_%0d: got addr %h data %h last %b required addr %h data %h last %b",
                             i, f_addr[i], f_data[i], f_last[i], 32'h1230 + 4*i, 32'hA000_0000 + i, i == 3);
                end
            end
        end
        checks++;
        if (wb_cnt !== 1 || wb_data !== 32'hA000_0002 || wb_rob !== 5'd5) begin
            errors++; $display("FAIL load_wb: got cnt %0d data %h rob %0d required 1 a0000002 5", wb_cnt, wb_data, wb_rob);
        end
        checks++;
        if (ack_q.size() !== 1 || cmp_q.size() !== 1) begin
            errors++; $display("FAIL load_pulses: got acks %0d completes %0d required 1 1", ack_q.size(), cmp_q.size());
        end else if (cmp_q[0] - ack_q[0] !== 6) begin
            errors++; $display("FAIL load_latency: got %0d required 6", cmp_q[0] - ack_q[0]);
        end
    endtask

    task automatic test_store_miss();
        clear_log();
        run_repair(32'h0000_0040, 32'hDEAD_BEEF, 5'd1, 1'b1, 32'hB000_0000);
        checks++;
        if (f_data.size() !== 4) begin errors++; $display("FAIL store_fill_count: got %0d required 4", f_data.size()); end
        else if (f_data[0] !== 32'hDEAD_BEEF || f_data[1] !== 32'hB000_0001 || f_data[2] !== 32'hB000_0002
                 || f_data[3] !== 32'hB000_0003 || f_addr[0] !== 32'h40 || f_addr[3] !== 32'h4C) begin
            errors++;
            $display("FAIL store_merge: got %h %h %h %h @%h required deadbeef b0000001 b0000002 b0000003 @40",
                     f_data[0], f_data[1], f_data[2], f_data[3], f_addr[0]);
        end
        checks++;
        if (wb_cnt !== 0 || cmp_q.size() !== 1) begin
            errors++; $display("FAIL store_wb_complete: got wb %0d completes %0d required 0 1", wb_cnt, cmp_q.size());
        end
    endtask

    task automatic test_stall_gaps();
        int bad;
        clear_log();
        bad = 0;
        @(posedge clk); #1;
        repair_req = 1'b1; repair_req_addr = 32'h2004; repair_req_rob_idx = 5'd7;
        repair_is_store = 1'b0; mem_req_ready = 1'b0;
        @(posedge clk); #1;
        repair_req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!(mem_req_valid === 1'b1 && mem_req_addr === 32'h2000)) bad++;
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_0000;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'h3000 + i;
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL stall_addr_stable: got %0d bad cycles required 0", bad); end
        checks++;
        if (f_data.size() !== 4) begin errors++; $display("FAIL stall_fill_count: got %0d required 4", f_data.size()); end
        else if (f_data[0] !== 32'h3000 || f_data[3] !== 32'h3003 || f_addr[1] !== 32'h2004 || f_last[3] !== 1'b1) begin
            errors++; $display("FAIL stall_fill_data: got %h %h @%h required 3000 3003 @2004", f_data[0], f_data[3], f_addr[1]);
        end
        checks++;
        if (wb_cnt !== 1 || wb_data !== 32'h3001 || wb_rob !== 5'd7) begin
            errors++; $display("FAIL stall_wb: got cnt %0d data %h rob %0d required 1 3001 7", wb_cnt, wb_data, wb_rob);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        @(posedge clk); #1;
        repair_req = 1'b1; repair_req_addr = 32'h80; repair_req_rob_idx = 5'd3;
        repair_is_store = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        for (int k = 0; k < 14; k++) begin
            mem_rsp_data = 32'hC000_0000 + k;
            @(posedge clk); #1;
        end
        repair_req = 1'b0; mem_rsp_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (ack_q.size() !== 2 || cmp_q.size() !== 2 || overlap !== 0) begin
            errors++; $display("FAIL b2b_counts: got acks %0d completes %0d overlap %0d required 2 2 0",
                               ack_q.size(), cmp_q.size(), overlap);
        end else if (ack_q[1] !== cmp_q[0] + 1) begin
            errors++; $display("FAIL b2b_reack: got ack at %0d required %0d", ack_q[1], cmp_q[0] + 1);
        end
        checks++;
        if (f_addr.size() !== 8 || wb_cnt !== 2 || wb_data !== 32'hC000_0009) begin
            errors++; $display("FAIL b2b_data: got fills %0d wb %0d data %h required 8 2 c0000009",
                               f_addr.size(), wb_cnt, wb_data);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        @(posedge clk); #1;
        repair_req = 1'b1; repair_req_addr = 32'h300; repair_req_rob_idx = 5'd9; repair_is_store = 1'b0;
        @(posedge clk); #1;
        repair_req = 1'b0;
        @(posedge clk); #1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hC0;
        @(posedge clk); #1; mem_rsp_data = 32'hC1;
        @(posedge clk); #1; rst = 1'b1; mem_rsp_data = 32'hC2; repair_req = 1'b1;
        #1;
        checks++;
        if (any_out !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got %b required 0", any_out); end
        @(posedge clk); #1; rst = 1'b0; repair_req = 1'b0; mem_rsp_data = 32'hC3;
        @(posedge clk); #1; mem_rsp_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (f_addr.size() !== 2 || cmp_q.size() !== 0 || wb_cnt !== 0) begin
            errors++; $display("FAIL midreset_abandon: got fills %0d completes %0d wb %0d required 2 0 0",
                               f_addr.size(), cmp_q.size(), wb_cnt);
        end
        clear_log();
        run_repair(32'h500, 32'h0, 5'd11, 1'b0, 32'h5000);
        checks++;
        if (f_addr.size() !== 4 || cmp_q.size() !== 1 || wb_data !== 32'h5000 || wb_rob !== 5'd11) begin
            errors++; $display("FAIL midreset_recover: got fills %0d completes %0d data %h rob %0d required 4 1 5000 11",
                               f_addr.size(), cmp_q.size(), wb_data, wb_rob);
        end else if (f_addr[0] !== 32'h500) begin
            errors++; $display("FAIL midreset_recover_addr: got %h required 500", f_addr[0]);
        end
    endtask

    task automatic test_last_word();
        clear_log();
        run_repair(32'h10C, 32'h0, 5'd4, 1'b0, 32'hD000);
        checks++;
        if (f_last.size() !== 4) begin errors++; $display("FAIL last_fill_count: got %0d required 4", f_last.size()); end
        else if (f_last[0] !== 1'b0 || f_last[1] !== 1'b0 || f_last[2] !== 1'b0 || f_last[3] !== 1'b1
                 || f_addr[3] !== 32'h10C) begin
            errors++; $display("FAIL last_flag: got %b%b%b%b @%h required 0001 @10c",
                               f_last[0], f_last[1], f_last[2], f_last[3], f_addr[3]);
        end
        checks++;
        if (wb_cnt !== 1 || wb_data !== 32'hD003 || wb_rob !== 5'd4) begin
            errors++; $display("FAIL last_wb: got cnt %0d data %h rob %0d required 1 d003 4", wb_cnt, wb_data, wb_rob);
        end
        clear_log();
        run_repair(32'h100, 32'h0, 5'd6, 1'b0, 32'hE000);
        checks++;
        if (f_addr.size() !== 4 || cmp_q.size() !== 1 || wb_data !== 32'hE000 || wb_rob !== 5'd6) begin
            errors++; $display("FAIL wrap_next: got fills %0d completes %0d data %h rob %0d required 4 1 e000 6",
                               f_addr.size(), cmp_q.size(), wb_data, wb_rob);
        end else if (f_addr[0] !== 32'h100 || f_addr[3] !== 32'h10C) begin
            errors++; $display("FAIL wrap_addr: got %h..%h required 100..10c", f_addr[0], f_addr[3]);
        end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_store_miss();
        test_stall_gaps();
        test_back_to_back();
        test_reset_mid();
        test_last_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
